fetch_stage: RTL and testbench

Instruction fetch stage of the five-stage MIPS pipeline, directly upstream of the decode stage. It owns the program counter and issues word requests to instruction memory over a request/ready handshake. It presents the fetched instruction and PC+4 to decode through a registered output. It also absorbs hazard stalls with a one-entry skid buffer and applies branch/jump redirects with flush.

---
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage.sv | 126 ++++++++++++
 tb/tb_fetch_stage.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready channel between the fetch stage and imem.
// The fetch stage uses the master side and the memory model uses the slave side.
interface fetch_stage_if #(
   parameter int SIZE = 32
);
   logic            imemReq;
   logic [SIZE-1:0] imemAddr;
   logic            imemReady;
   logic [SIZE-1:0] imemData;

   modport master (
      output imemReq,
      output imemAddr,
      input  imemReady,
      input  imemData
   );

   modport slave (
      input  imemReq,
      input  imemAddr,
      output imemReady,
      output imemData
   );
endinterface

// File: rtl/fetch_stage.sv
// MIPS fetch stage: owns the pc, fetches over a req/ready channel, and feeds decode
// through a registered output with a one-entry skid buffer and branch redirect/flush.
//
// state | meaning
// REQ   | request outstanding at pc; a completion loads the output or skid buffer
// BUF   | skid buffer holds the word that completed under stall; no request issued
module fetch_stage #(
   parameter int              SIZE     = 32,
   parameter logic [SIZE-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            branchTaken,
   input  logic [SIZE-1:0] branchTarget,
   fetch_stage_if.master   imem,
   output logic [SIZE-1:0] instruction,
   output logic [SIZE-1:0] pcPlus4,
   output logic            valid
);

   typedef enum logic {REQ, BUF} state_t;

   state_t          state, state_nxt;
   logic [SIZE-1:0] pc, pc_nxt;
   logic [SIZE-1:0] buf_instr, buf_instr_nxt;
   logic [SIZE-1:0] buf_pc4, buf_pc4_nxt;
   logic [SIZE-1:0] pending_target, pending_target_nxt;
   logic            discard, discard_nxt;
   logic [SIZE-1:0] instruction_nxt, pc_plus4_nxt;
   logic            valid_nxt;
   logic [SIZE-1:0] target_aligned;
   logic [SIZE-1:0] pc_inc;

   assign target_aligned = branchTarget & ~SIZE'(3);
   assign pc_inc         = pc + SIZE'(4);

   assign imem.imemReq  = (state == REQ) && !rst;
   assign imem.imemAddr = pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= REQ;
         pc             <= RESET_PC;
         buf_instr      <= '0;
         buf_pc4        <= '0;
         pending_target <= '0;
         discard        <= 1'b0;
         instruction    <= '0;
         pcPlus4        <= '0;
         valid          <= 1'b0;
      end else begin
         state          <= state_nxt;
         pc             <= pc_nxt;
         buf_instr      <= buf_instr_nxt;
         buf_pc4        <= buf_pc4_nxt;
         pending_target <= pending_target_nxt;
         discard        <= discard_nxt;
         instruction    <= instruction_nxt;
         pcPlus4        <= pc_plus4_nxt;
         valid          <= valid_nxt;
      end
   end

   always_comb begin
      state_nxt          = state;
      pc_nxt             = pc;
      buf_instr_nxt      = buf_instr;
      buf_pc4_nxt        = buf_pc4;
      pending_target_nxt = pending_target;
      discard_nxt        = discard;
      instruction_nxt    = instruction;
      pc_plus4_nxt       = pcPlus4;
      valid_nxt          = valid;

      case (state)
         REQ: begin
            if (imem.imemReady) begin
               if (branchTaken) begin
                  pc_nxt      = target_aligned;
                  discard_nxt = 1'b0;
                  valid_nxt   = 1'b0;
               end else if (discard) begin
                  // word belongs to the flushed path; now fetch the remembered target
                  pc_nxt      = pending_target;
                  discard_nxt = 1'b0;
                  if (!stall) valid_nxt = 1'b0;
               end else if (!stall) begin
                  instruction_nxt = imem.imemData;
                  pc_plus4_nxt    = pc_inc;
                  valid_nxt       = 1'b1;
                  pc_nxt          = pc_inc;
               end else begin
                  buf_instr_nxt = imem.imemData;
                  buf_pc4_nxt   = pc_inc;
                  pc_nxt        = pc_inc;
                  state_nxt     = BUF;
               end
            end else begin
               // address must stay stable until ready, so the redirect is deferred
               if (branchTaken) begin
                  discard_nxt        = 1'b1;
                  pending_target_nxt = target_aligned;
                  valid_nxt          = 1'b0;
               end else if (!stall) begin
                  valid_nxt = 1'b0;
               end
            end
         end
         BUF: begin
            if (branchTaken) begin
               pc_nxt    = target_aligned;
               valid_nxt = 1'b0;
               state_nxt = REQ;
            end else if (!stall) begin
               instruction_nxt = buf_instr;
               pc_plus4_nxt    = buf_pc4;
               valid_nxt       = 1'b1;
               state_nxt       = REQ;
            end
         end
         default: state_nxt = REQ;
      endcase
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle vector table plus an in-order scoreboard of
// delivered instructions, with a wait-state memory model that returns addr>>2.
module tb_fetch_stage;
   localparam int SIZE = 32;

   logic        clk = 1'b0;
   logic        rst, stall, branchTaken;
   logic [31:0] branchTarget;
   logic [31:0] instruction, pcPlus4;
   logic        valid;

   fetch_stage_if #(.SIZE(SIZE)) bus ();

   fetch_stage #(.SIZE(SIZE), .RESET_PC(32'h0)) dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .branchTaken(branchTaken),
      .branchTarget(branchTarget),
      .imem(bus),
      .instruction(instruction),
      .pcPlus4(pcPlus4),
      .valid(valid)
   );

   always #5 clk = ~clk;

   int wait_n = 0;
   int wcnt = 0;
   always @(posedge clk) begin
      if (!bus.imemReq || bus.imemReady) wcnt <= 0;
      else wcnt <= wcnt + 1;
   end
   assign bus.imemReady = bus.imemReq && (wcnt == wait_n);
   assign bus.imemData  = bus.imemAddr >> 2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int          seg;
      logic [31:0] instr;
      logic [31:0] pc4;
   } sexp_t;
   sexp_t exps[$];

   typedef struct {
      int          seg;
      int          wt;
      logic        st;
      logic        br;
      logic [31:0] tgt;
      logic        req;
      logic [31:0] addr;
      logic        v;
      logic [31:0] ins;
   } row_t;
   row_t rows[$];

   function automatic row_t mk(int seg, int wt, logic st, logic br, logic [31:0] tgt,
                               logic req, logic [31:0] addr, logic v, logic [31:0] ins);
      row_t r;
      r.seg = seg; r.wt = wt; r.st = st; r.br = br; r.tgt = tgt;
      r.req = req; r.addr = addr; r.v = v; r.ins = ins;
      return r;
   endfunction

   function automatic sexp_t mx(int seg, logic [31:0] instr, logic [31:0] pc4);
      sexp_t e;
      e.seg = seg; e.instr = instr; e.pc4 = pc4;
      return e;
   endfunction

   // Output is new when it was loaded at the last edge, i.e. stall was low there.
   always @(posedge clk) begin
      logic ps;
      exp_t e;
      ps = stall;
      #1;
      if (valid && !ps) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_extra got instr=%h pc4=%h expected nothing", instruction, pcPlus4);
         end else begin
            e = sb.pop_front();
            if (instruction !== e.instr || pcPlus4 !== e.pc4) begin
               errors++;
               $display("FAIL sb_order got instr=%h pc4=%h expected instr=%h pc4=%h",
                        instruction, pcPlus4, e.instr, e.pc4);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic start_segment(input int s);
      rst = 1'b1; stall = 1'b0; branchTaken = 1'b0; branchTarget = '0; wait_n = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk($sformatf("seg%0d_rst_valid", s), {31'b0, valid}, 32'h0);
      chk($sformatf("seg%0d_rst_instr", s), instruction, 32'h0);
      chk($sformatf("seg%0d_rst_pc4", s), pcPlus4, 32'h0);
      chk($sformatf("seg%0d_rst_req", s), {31'b0, bus.imemReq}, 32'h0);
      chk($sformatf("seg%0d_rst_addr", s), bus.imemAddr, 32'h0);
      foreach (exps[k]) begin
         if (exps[k].seg == s) begin
            exp_t e;
            e.instr = exps[k].instr;
            e.pc4   = exps[k].pc4;
            sb.push_back(e);
         end
      end
      rst = 1'b0;
   endtask

   task automatic end_segment(input int s);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL seg%0d_sb_missing got %0d undelivered expected 0", s, sb.size());
      end
      sb.delete();
   endtask

   task automatic check_row(input int i);
      string n;
      n = $sformatf("row%0d_seg%0d", i, rows[i].seg);
      chk({n, "_req"}, {31'b0, bus.imemReq}, {31'b0, rows[i].req});
      chk({n, "_addr"}, bus.imemAddr, rows[i].addr);
      chk({n, "_valid"}, {31'b0, valid}, {31'b0, rows[i].v});
      if (rows[i].v) chk({n, "_instr"}, instruction, rows[i].ins);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; branchTaken = 1'b0; branchTarget = '0;

      // seg1: zero-wait streaming from reset
      rows.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0,  0, 0));
      rows.push_back(mk(1, 0, 0, 0, 0, 1, 32'h4,  1, 0));
      rows.push_back(mk(1, 0, 0, 0, 0, 1, 32'h8,  1, 1));
      rows.push_back(mk(1, 0, 0, 0, 0, 1, 32'hC,  1, 2));
      for (int k = 0; k < 3; k++) exps.push_back(mx(1, k, 4 * k + 4));
      // seg2: two wait cycles per request
      for (int c = 0; c < 11; c++)
         rows.push_back(mk(2, 2, 0, 0, 0, 1, 32'(4 * (c / 3)), (c % 3 == 0) && (c > 0),
                           32'(c / 3 - 1)));
      for (int k = 0; k < 3; k++) exps.push_back(mx(2, k, 4 * k + 4));
      // seg3: stall while word 5 is presented and word 6 lands in the buffer
      for (int c = 0; c < 6; c++)
         rows.push_back(mk(3, 0, 0, 0, 0, 1, 32'(4 * c), c > 0, 32'(c - 1)));
      rows.push_back(mk(3, 0, 1, 0, 0, 1, 32'd24, 1, 5));
      rows.push_back(mk(3, 0, 1, 0, 0, 0, 32'd28, 1, 5));
      rows.push_back(mk(3, 0, 1, 0, 0, 0, 32'd28, 1, 5));
      rows.push_back(mk(3, 0, 0, 0, 0, 0, 32'd28, 1, 5));
      rows.push_back(mk(3, 0, 0, 0, 0, 1, 32'd28, 1, 6));
      rows.push_back(mk(3, 0, 0, 0, 0, 1, 32'd32, 1, 7));
      for (int k = 0; k < 8; k++) exps.push_back(mx(3, k, 4 * k + 4));
      // seg4: redirect in the completion cycle, misaligned target
      rows.push_back(mk(4, 0, 0, 0, 0,            1, 32'h0,   0, 0));
      rows.push_back(mk(4, 0, 0, 0, 0,            1, 32'h4,   1, 0));
      rows.push_back(mk(4, 0, 0, 0, 0,            1, 32'h8,   1, 1));
      rows.push_back(mk(4, 0, 0, 1, 32'h103,      1, 32'hC,   1, 2));
      rows.push_back(mk(4, 0, 0, 0, 0,            1, 32'h100, 0, 0));
      rows.push_back(mk(4, 0, 0, 0, 0,            1, 32'h104, 1, 32'h40));
      rows.push_back(mk(4, 0, 0, 0, 0,            1, 32'h108, 1, 32'h41));
      exps.push_back(mx(4, 0, 4)); exps.push_back(mx(4, 1, 8)); exps.push_back(mx(4, 2, 12));
      exps.push_back(mx(4, 32'h40, 32'h104)); exps.push_back(mx(4, 32'h41, 32'h108));
      // seg5: redirect to 0x200 while the 0x40 request is two cycles from ready
      rows.push_back(mk(5, 0, 0, 1, 32'h40,  1, 32'h0,   0, 0));
      rows.push_back(mk(5, 2, 0, 1, 32'h200, 1, 32'h40,  0, 0));
      rows.push_back(mk(5, 2, 0, 0, 0,       1, 32'h40,  0, 0));
      rows.push_back(mk(5, 2, 0, 0, 0,       1, 32'h40,  0, 0));
      rows.push_back(mk(5, 2, 0, 0, 0,       1, 32'h200, 0, 0));
      rows.push_back(mk(5, 2, 0, 0, 0,       1, 32'h200, 0, 0));
      rows.push_back(mk(5, 2, 0, 0, 0,       1, 32'h200, 0, 0));
      rows.push_back(mk(5, 2, 0, 0, 0,       1, 32'h204, 1, 32'h80));
      exps.push_back(mx(5, 32'h80, 32'h204));
      // seg7: pc wraps past the top of the address space
      rows.push_back(mk(7, 0, 0, 1, 32'hFFFF_FFFF, 1, 32'h0,         0, 0));
      rows.push_back(mk(7, 0, 0, 0, 0,             1, 32'hFFFF_FFFC, 0, 0));
      rows.push_back(mk(7, 0, 0, 0, 0,             1, 32'h0,         1, 32'h3FFF_FFFF));
      exps.push_back(mx(7, 32'h3FFF_FFFF, 32'h0));
      // seg6: branch and stall together while in BUF
      rows.push_back(mk(6, 0, 0, 0, 0,       1, 32'h0,   0, 0));
      rows.push_back(mk(6, 0, 1, 0, 0,       1, 32'h4,   1, 0));
      rows.push_back(mk(6, 0, 1, 1, 32'h300, 0, 32'h8,   1, 0));
      rows.push_back(mk(6, 0, 0, 0, 0,       1, 32'h300, 0, 0));
      rows.push_back(mk(6, 0, 0, 0, 0,       1, 32'h304, 1, 32'hC0));
      exps.push_back(mx(6, 0, 4)); exps.push_back(mx(6, 32'hC0, 32'h304));

      for (int i = 0; i < rows.size(); i++) begin
         if (i == 0 || rows[i].seg != rows[i-1].seg) begin
            if (i > 0) end_segment(rows[i-1].seg);
            start_segment(rows[i].seg);
         end else begin
            @(posedge clk); #1;
         end
         wait_n       = rows[i].wt;
         stall        = rows[i].st;
         branchTaken  = rows[i].br;
         branchTarget = rows[i].tgt;
         #1;
         check_row(i);
      end
      end_segment(rows[rows.size()-1].seg);

      // reset in the middle of an outstanding request
      exps.push_back(mx(9, 32'h20, 32'h84));
      start_segment(9);
      branchTaken = 1'b1; branchTarget = 32'h80; wait_n = 0;
      @(posedge clk); #1;
      branchTaken = 1'b0; wait_n = 2;
      repeat (3) begin @(posedge clk); #1; end
      chk("midrst_pre_addr", bus.imemAddr, 32'h84);
      chk("midrst_pre_instr", instruction, 32'h20);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_req_drop", {31'b0, bus.imemReq}, 32'h0);
      @(posedge clk); #1;
      chk("midrst_valid", {31'b0, valid}, 32'h0);
      chk("midrst_instr", instruction, 32'h0);
      chk("midrst_pc4", pcPlus4, 32'h0);
      chk("midrst_addr", bus.imemAddr, 32'h0);
      end_segment(9);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_req", {31'b0, bus.imemReq}, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
